hyp_share_arbiter: RTL
======================

HYP_SHARE_ARBITER -- requirements
Module: hyp_share_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of requesters (forward/backward cell element-wise paths).
REQ-002 SHALL have parameter DATA_W, default 16: fixed-point operand/result width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit in WAIT; used only with HYP_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  N_REQ  per-requester request level.
REQ-007 SHALL have port req_data  input  N_REQ*DATA_W  operands; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port gnt  output  N_REQ  one-hot, one-cycle grant pulse.
REQ-009 SHALL have port rsp_valid  output  N_REQ  one-hot, one-cycle result pulse.
REQ-010 SHALL have port rsp_data  output  DATA_W  result, valid when any rsp_valid bit is high.
REQ-011 SHALL have port hyp_start  output  1  one-cycle start pulse to the shared hyperbolic unit.
REQ-012 SHALL have port hyp_in  output  DATA_W  operand to the hyperbolic unit, stable from hyp_start until hyp_done.
REQ-013 SHALL have port hyp_done  input  1  result-ready pulse from the hyperbolic unit.
REQ-014 SHALL have port hyp_out  input  DATA_W  hyperbolic result, sampled when hyp_done is high.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port timeout_err  output  1  one-cycle watchdog pulse.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-018 IDLE with any req bit high SHALL select winner w round-robin, searching upward from pointer ptr and wrapping at N_REQ-1 to 0.
REQ-019 On that edge SHALL register gnt[w]=1, hyp_start=1, hyp_in=req_data slice w, owner=w; next state WAIT.
REQ-020 WAIT SHALL clear gnt and hyp_start after one cycle and hold hyp_in and owner.
REQ-021 WAIT with hyp_done=1, including the first WAIT cycle, SHALL register rsp_data=hyp_out, rsp_valid[owner]=1, ptr=(owner+1) mod N_REQ; next state RESP.
REQ-022 RESP SHALL clear rsp_valid and return to IDLE; minimum grant-to-grant spacing is 3 cycles.
REQ-023 req SHALL be sampled only in IDLE; requesters drop req after gnt, and a req still high in IDLE is a new request.
REQ-024 hyp_done outside WAIT SHALL be ignored with no output change.
REQ-025 A single active requester SHALL be granted regardless of ptr; with none active, the FSM stays in IDLE and ptr holds.
REQ-026 Worst-case wait for any requester SHALL be N_REQ-1 service slots.

Reset
REQ-027 rst high SHALL immediately force state=IDLE, ptr=0, owner=0, gnt=0, rsp_valid=0, rsp_data=0, hyp_start=0, hyp_in=0, busy=0, timeout_err=0, watchdog=0.
REQ-028 Reset mid-WAIT SHALL abandon the operation with no rsp_valid; a later stray hyp_done is ignored per REQ-024.

Configuration
REQ-029 Macro HYP_ARB_TIMEOUT_EN defined: the watchdog counts WAIT cycles, clears on WAIT entry, and on reaching TIMEOUT_CYCLES without hyp_done registers rsp_valid[owner]=1, rsp_data=0, timeout_err=1, advances ptr, and goes to RESP.
REQ-030 hyp_done and timeout in the same cycle SHALL complete normally with no error.
REQ-031 Macro undefined: no counter logic; WAIT lasts indefinitely; timeout_err tied 0.

Structure
REQ-032 Package ew_pkg SHALL hold the FSM state encoding and the default DATA_W/N_REQ constants.
REQ-033 Sub-module rr_pick SHALL be the combinational round-robin selector (inputs req, ptr; outputs one-hot win, index, any).

Verification
REQ-034 Bench SHALL cover: req=01, data0=0x0100, hyp_done 5 cycles after hyp_start with hyp_out=0x00F5 -> gnt=01, then rsp_valid=01, rsp_data=0x00F5.
REQ-035 Bench SHALL cover: req=11 held continuously, ptr=0 -> grants alternate 01,10,01; each hyp_in matches the granted slice.
REQ-036 Bench SHALL cover: hyp_done pulsed in IDLE -> no rsp_valid, busy stays 0.
REQ-037 Bench SHALL cover: rst asserted 2 cycles into WAIT, then hyp_done -> no rsp_valid; all outputs 0; next grant goes to requester 0.
REQ-038 Bench SHALL cover, with HYP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: hyp_done never asserted -> after 8 WAIT cycles rsp_valid[owner]=1, rsp_data=0, timeout_err=1 for one cycle.
REQ-039 Bench SHALL cover, with HYP_ARB_TIMEOUT_EN: hyp_done on the exact timeout cycle -> normal response with timeout_err=0.

Source files
------------

// File: rtl/hyp_share_arbiter_pkg.sv
// Shared definitions for the hyperbolic-unit share arbiter: FSM state
// encoding, default sizing constants and an index-width helper.
package ew_pkg;

    localparam int EW_N_REQ  = 2;
    localparam int EW_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Width of a requester index; never zero so a single requester still
    // gets a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hyp_share_arbiter_if.sv
// Bus between the share arbiter, its requesters and the shared hyperbolic
// unit. The master modport is the arbiter's view; slave is the environment.
interface hyp_share_arbiter_if
    import ew_pkg::*;
#(
    parameter int N_REQ  = EW_N_REQ,
    parameter int DATA_W = EW_DATA_W
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    hyp_start;
    logic [DATA_W-1:0]       hyp_in;
    logic                    hyp_done;
    logic [DATA_W-1:0]       hyp_out;
    logic                    busy;
    logic                    timeout_err;

    modport master (
        input  req, req_data, hyp_done, hyp_out,
        output gnt, rsp_valid, rsp_data, hyp_start, hyp_in, busy, timeout_err
    );

    modport slave (
        output req, req_data, hyp_done, hyp_out,
        input  gnt, rsp_valid, rsp_data, hyp_start, hyp_in, busy, timeout_err
    );

endinterface

// File: rtl/hyp_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request found searching
// upward from ptr, wrapping from N_REQ-1 back to 0.
module rr_pick
    import ew_pkg::*;
#(
    parameter  int N_REQ = EW_N_REQ,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    int k;

    // Scan N_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        win   = '0;
        index = '0;
        any   = 1'b0;
        k     = 0;
        for (int off = 0; off < N_REQ; off++) begin
            k = int'(ptr) + off;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!any && req[k]) begin
                any    = 1'b1;
                win[k] = 1'b1;
                index  = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/hyp_share_arbiter.sv
// Round-robin arbiter sharing one hyperbolic unit between N_REQ requesters.
// Flow per request: IDLE (grant + start) -> WAIT (hold operand until
// hyp_done) -> RESP (one-cycle result pulse) -> IDLE. All outputs registered.
// Optional watchdog: define HYP_ARB_TIMEOUT_EN to abort a WAIT that sees no
// hyp_done within TIMEOUT_CYCLES cycles (zero result, timeout_err pulse).
module hyp_share_arbiter
    import ew_pkg::*;
#(
    parameter  int N_REQ          = EW_N_REQ,
    parameter  int DATA_W         = EW_DATA_W,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int IDX_W          = idx_w(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    hyp_share_arbiter_if.master  arb_bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e        r_state,       w_state_nxt;
    logic [IDX_W-1:0]  r_ptr,         w_ptr_nxt;
    logic [IDX_W-1:0]  r_owner,       w_owner_nxt;
    logic [N_REQ-1:0]  r_gnt,         w_gnt_nxt;
    logic [N_REQ-1:0]  r_rsp_valid,   w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_data,    w_rsp_data_nxt;
    logic              r_hyp_start,   w_hyp_start_nxt;
    logic [DATA_W-1:0] r_hyp_in,      w_hyp_in_nxt;
    logic              r_busy,        w_busy_nxt;

`ifdef HYP_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]   r_wdog,        w_wdog_nxt;
    logic              r_timeout_err, w_timeout_err_nxt;
`endif

    logic [N_REQ-1:0]  w_win;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_any;
    logic [IDX_W-1:0]  w_owner_inc;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req   (arb_bus.req),
        .ptr   (r_ptr),
        .win   (w_win),
        .index (w_win_idx),
        .any   (w_any)
    );

    // Pointer moves to the requester just after the one served.
    assign w_owner_inc = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    // Next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_data_nxt  = r_rsp_data;
        w_hyp_start_nxt = 1'b0;
        w_hyp_in_nxt    = r_hyp_in;
`ifdef HYP_ARB_TIMEOUT_EN
        w_wdog_nxt        = r_wdog;
        w_timeout_err_nxt = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt       = w_win;
                    w_hyp_start_nxt = 1'b1;
                    w_hyp_in_nxt    = arb_bus.req_data[w_win_idx*DATA_W +: DATA_W];
                    w_owner_nxt     = w_win_idx;
                    w_state_nxt     = ST_WAIT;
`ifdef HYP_ARB_TIMEOUT_EN
                    w_wdog_nxt      = '0;
`endif
                end
            end
            ST_WAIT: begin
                // hyp_done wins over a coincident watchdog expiry.
                if (arb_bus.hyp_done) begin
                    w_rsp_data_nxt           = arb_bus.hyp_out;
                    w_rsp_valid_nxt[r_owner] = 1'b1;
                    w_ptr_nxt                = w_owner_inc;
                    w_state_nxt              = ST_RESP;
                end
`ifdef HYP_ARB_TIMEOUT_EN
                else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    w_rsp_data_nxt           = '0;
                    w_rsp_valid_nxt[r_owner] = 1'b1;
                    w_timeout_err_nxt        = 1'b1;
                    w_ptr_nxt                = w_owner_inc;
                    w_state_nxt              = ST_RESP;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_hyp_start <= 1'b0;
            r_hyp_in    <= '0;
            r_busy      <= 1'b0;
`ifdef HYP_ARB_TIMEOUT_EN
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_hyp_start <= w_hyp_start_nxt;
            r_hyp_in    <= w_hyp_in_nxt;
            r_busy      <= w_busy_nxt;
`ifdef HYP_ARB_TIMEOUT_EN
            r_wdog        <= w_wdog_nxt;
            r_timeout_err <= w_timeout_err_nxt;
`endif
        end
    end

    assign arb_bus.gnt       = r_gnt;
    assign arb_bus.rsp_valid = r_rsp_valid;
    assign arb_bus.rsp_data  = r_rsp_data;
    assign arb_bus.hyp_start = r_hyp_start;
    assign arb_bus.hyp_in    = r_hyp_in;
    assign arb_bus.busy      = r_busy;
`ifdef HYP_ARB_TIMEOUT_EN
    assign arb_bus.timeout_err = r_timeout_err;
`else
    assign arb_bus.timeout_err = 1'b0;
`endif

endmodule
